// File: rtl/elevator_pkg.sv
// Shared definitions for the SCAN elevator controller: engine encoding, FSM states, width helper.
package elevator_pkg;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE      = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } elev_state_t;

  // Bits needed to index n items (floors or counter values), never below 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_ctrl_scan_if.sv
// Button front-end and motor/door/display signals between IO and the elevator controller.
interface elevator_ctrl_scan_if #(
  parameter int FLOORS = 6
);

  logic              open_btn;
  logic              close_btn;
  logic [FLOORS-1:0] btn_num_in;
  logic [FLOORS-1:0] btn_up_out;
  logic [FLOORS-1:0] btn_down_out;
  logic [1:0]        engine;
  logic              door;
  logic [FLOORS-1:0] level_display;
  logic [FLOORS-1:0] pending;
  logic              dir_up;

  modport master (
    output open_btn, close_btn, btn_num_in, btn_up_out, btn_down_out,
    input  engine, door, level_display, pending, dir_up
  );

  modport slave (
    input  open_btn, close_btn, btn_num_in, btn_up_out, btn_down_out,
    output engine, door, level_display, pending, dir_up
  );

endinterface

// File: rtl/elevator_req_latch.sv
// Set/clear latch bank for one request class; bits outside VALID can never be set.
module elevator_req_latch
  import elevator_pkg::*;
#(
  parameter int                FLOORS = 6,
  parameter logic [FLOORS-1:0] VALID  = {FLOORS{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] set_mask,
  input  logic [FLOORS-1:0] clr_mask,
  output logic [FLOORS-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= ((q & ~clr_mask) | set_mask) & VALID;
    end
  end

endmodule

// File: rtl/elevator_ctrl_scan.sv
// SCAN-ordered single-cabin elevator controller: request latching, travel timing, door dwell.
//   state        | meaning
//   ST_IDLE      | door closed, cabin parked, choosing the next action
//   ST_MOVE      | engine driven one floor at a time in dir_up
//   ST_DOOR_OPEN | door open, dwell timer counting down
module elevator_ctrl_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 6,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input logic                 clk,
  input logic                 reset,
  elevator_ctrl_scan_if.slave bus
);

  localparam int                TW       = idx_w(TRAVEL_CYCLES);
  localparam int                DW       = idx_w(DOOR_CYCLES);
  localparam logic [FLOORS-1:0] ONE      = FLOORS'(1);
  localparam logic [FLOORS-1:0] UP_VALID = ~(ONE << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DN_VALID = ~ONE;
  localparam logic [TW-1:0]     T_LAST   = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]     D_LOAD   = DW'(DOOR_CYCLES - 1);

  // Floors strictly above / below a one-hot position.
  function automatic logic [FLOORS-1:0] above(input logic [FLOORS-1:0] l);
    return ~((l << 1) - ONE);
  endfunction

  function automatic logic [FLOORS-1:0] below(input logic [FLOORS-1:0] l);
    return l - ONE;
  endfunction

  elev_state_t       state, state_nxt;
  logic [FLOORS-1:0] level, step_level;
  logic              dir_q, door_entry;
  logic [TW-1:0]     tcnt;
  logic [DW-1:0]     dcnt;
  logic [FLOORS-1:0] cab_q, up_q, dn_q, req, hall_dir, hall_opp;
  logic [FLOORS-1:0] block_set, cab_clr, up_clr, dn_clr, pending_q;
  logic              ahead_cur, behind_cur, ahead_step, here, stop_step;
  logic              t_last, floor_press, open_req;

  assign req        = cab_q | up_q | dn_q;
  assign hall_dir   = dir_q ? up_q : dn_q;
  assign hall_opp   = dir_q ? dn_q : up_q;
  assign step_level = dir_q ? (level << 1) : (level >> 1);
  assign ahead_cur  = |(req & (dir_q ? above(level) : below(level)));
  assign behind_cur = |(req & (dir_q ? below(level) : above(level)));
  assign ahead_step = |(req & (dir_q ? above(step_level) : below(step_level)));

  // An opposite-direction hall call here only counts once nothing is left ahead,
  // otherwise the door would reopen forever without serving it.
  assign here      = |(level & (cab_q | hall_dir | (hall_opp & {FLOORS{~ahead_cur}})));
  assign stop_step = |(step_level & (cab_q | hall_dir)) | ~ahead_step;
  assign t_last    = (tcnt == T_LAST);

  assign floor_press = (state == ST_DOOR_OPEN) &&
                       |(level & (bus.btn_num_in | (bus.btn_up_out & UP_VALID) |
                                  (bus.btn_down_out & DN_VALID)));
  assign open_req    = bus.open_btn | floor_press;
  assign block_set   = (state == ST_DOOR_OPEN) ? level : '0;

  always_comb begin
    cab_clr = '0;
    up_clr  = '0;
    dn_clr  = '0;
    if (state == ST_DOOR_OPEN && door_entry) begin
      cab_clr = level;
      if (dir_q || !ahead_cur) up_clr = level;
      if (!dir_q || !ahead_cur) dn_clr = level;
    end
  end

  elevator_req_latch #(.FLOORS(FLOORS), .VALID({FLOORS{1'b1}})) u_cab (
    .clk      (clk),
    .rst_n    (reset),
    .set_mask (bus.btn_num_in & ~block_set),
    .clr_mask (cab_clr),
    .q        (cab_q)
  );

  elevator_req_latch #(.FLOORS(FLOORS), .VALID(UP_VALID)) u_up (
    .clk      (clk),
    .rst_n    (reset),
    .set_mask (bus.btn_up_out & ~block_set),
    .clr_mask (up_clr),
    .q        (up_q)
  );

  elevator_req_latch #(.FLOORS(FLOORS), .VALID(DN_VALID)) u_dn (
    .clk      (clk),
    .rst_n    (reset),
    .set_mask (bus.btn_down_out & ~block_set),
    .clr_mask (dn_clr),
    .q        (dn_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (here || bus.open_btn) state_nxt = ST_DOOR_OPEN;
        else if (ahead_cur || behind_cur) state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        if (t_last && stop_step) state_nxt = ST_DOOR_OPEN;
      end
      ST_DOOR_OPEN: begin
        if (!open_req && dcnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.engine = ENG_STOP;
    bus.door   = 1'b0;
    case (state)
      ST_MOVE:      bus.engine = dir_q ? ENG_UP : ENG_DOWN;
      ST_DOOR_OPEN: bus.door   = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level      <= ONE;
      dir_q      <= 1'b1;
      tcnt       <= '0;
      dcnt       <= '0;
      door_entry <= 1'b0;
    end else begin
      door_entry <= (state != ST_DOOR_OPEN) && (state_nxt == ST_DOOR_OPEN);
      if (state != ST_DOOR_OPEN && state_nxt == ST_DOOR_OPEN) dcnt <= D_LOAD;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (state_nxt == ST_MOVE && !ahead_cur) dir_q <= ~dir_q;
        end
        ST_MOVE: begin
          if (t_last) begin
            level <= step_level;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_DOOR_OPEN: begin
          if (door_entry && !ahead_cur) dir_q <= ~dir_q;
          // open wins over close; close parks the timer at zero so the next edge expires
          if (open_req) dcnt <= D_LOAD;
          else if (bus.close_btn) dcnt <= '0;
          else if (dcnt != '0) dcnt <= dcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= req;
    end
  end

  assign bus.level_display = level;
  assign bus.pending       = pending_q;
  assign bus.dir_up        = dir_q;

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Randomized and directed bench for elevator_ctrl_scan against a floor-number/array reference model.
module tb_elevator_ctrl_scan;

  localparam int F = 6;
  localparam int T = 4;
  localparam int D = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_MOVE = 1;
  localparam int PH_DOOR = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elevator_ctrl_scan_if #(.FLOORS(F)) bus ();

  elevator_ctrl_scan #(.FLOORS(F), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: cabin floor as an integer, requests as per-floor flags
  int         m_ph, m_fl, m_t, m_d;
  bit         m_dir, m_entry;
  bit         m_cab[F], m_up[F], m_dn[F];
  logic [F-1:0] m_pend;

  int         n_up_cyc, n_door_cyc;
  bit         prev_door;
  logic [F-1:0] door_floors[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit any_beyond(input int f, input bit up);
    bit r = 1'b0;
    for (int i = 0; i < F; i++)
      if ((up && i > f) || (!up && i < f)) r = r | m_cab[i] | m_up[i] | m_dn[i];
    return r;
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_fl = 0; m_dir = 1'b1; m_t = 0; m_d = 0; m_entry = 1'b0;
    for (int i = 0; i < F; i++) begin
      m_cab[i] = 1'b0; m_up[i] = 1'b0; m_dn[i] = 1'b0;
    end
    m_pend = '0;
    prev_door = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs held across it.
  task automatic model_step(input logic [F-1:0] c, input logic [F-1:0] u,
                            input logic [F-1:0] dn, input bit op, input bit cl);
    bit n_cab[F], n_up[F], n_dn[F];
    bit ahead, press_here, here, stop, n_dir;
    int n_ph, n_fl, n_t, n_d, nf;
    n_cab = m_cab; n_up = m_up; n_dn = m_dn;
    n_ph = m_ph; n_fl = m_fl; n_t = m_t; n_d = m_d; n_dir = m_dir;
    for (int i = 0; i < F; i++) m_pend[i] = m_cab[i] | m_up[i] | m_dn[i];
    ahead = any_beyond(m_fl, m_dir);
    press_here = 1'b0;
    if (m_ph == PH_DOOR && m_entry) begin
      n_cab[m_fl] = 1'b0;
      if (m_dir) n_up[m_fl] = 1'b0; else n_dn[m_fl] = 1'b0;
      if (!ahead) begin n_up[m_fl] = 1'b0; n_dn[m_fl] = 1'b0; end
    end
    for (int i = 0; i < F; i++) begin
      bit hit_c, hit_u, hit_d;
      hit_c = c[i];
      hit_u = u[i] && (i < F - 1);
      hit_d = dn[i] && (i > 0);
      if (m_ph == PH_DOOR && i == m_fl) begin
        if (hit_c || hit_u || hit_d) press_here = 1'b1;
      end else begin
        if (hit_c) n_cab[i] = 1'b1;
        if (hit_u) n_up[i] = 1'b1;
        if (hit_d) n_dn[i] = 1'b1;
      end
    end
    case (m_ph)
      PH_IDLE: begin
        here = m_cab[m_fl] || (m_dir ? m_up[m_fl] : m_dn[m_fl]) ||
               ((m_dir ? m_dn[m_fl] : m_up[m_fl]) && !ahead);
        if (here || op) begin
          n_ph = PH_DOOR; n_d = D - 1;
        end else if (ahead) begin
          n_ph = PH_MOVE; n_t = 0;
        end else if (any_beyond(m_fl, !m_dir)) begin
          n_ph = PH_MOVE; n_t = 0; n_dir = !m_dir;
        end
      end
      PH_MOVE: begin
        if (m_t == T - 1) begin
          nf = m_dir ? m_fl + 1 : m_fl - 1;
          n_fl = nf; n_t = 0;
          stop = m_cab[nf] || (m_dir ? m_up[nf] : m_dn[nf]) || !any_beyond(nf, m_dir);
          if (stop) begin n_ph = PH_DOOR; n_d = D - 1; end
        end else begin
          n_t = m_t + 1;
        end
      end
      default: begin
        if (m_entry && !ahead) n_dir = !m_dir;
        if (op || press_here) n_d = D - 1;
        else if (m_d == 0) n_ph = PH_IDLE;
        else if (cl) n_d = 0;
        else n_d = m_d - 1;
      end
    endcase
    m_entry = (m_ph != PH_DOOR) && (n_ph == PH_DOOR);
    m_cab = n_cab; m_up = n_up; m_dn = n_dn;
    m_ph = n_ph; m_fl = n_fl; m_t = n_t; m_d = n_d; m_dir = n_dir;
  endtask

  task automatic compare_outputs();
    logic [1:0]   e_eng;
    logic [F-1:0] e_lvl;
    e_eng = (m_ph == PH_MOVE) ? (m_dir ? 2'b01 : 2'b10) : 2'b00;
    e_lvl = '0;
    e_lvl[m_fl] = 1'b1;
    chk("engine", 32'(bus.engine), 32'(e_eng));
    chk("door", 32'(bus.door), 32'(m_ph == PH_DOOR));
    chk("level_display", 32'(bus.level_display), 32'(e_lvl));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("dir_up", 32'(bus.dir_up), 32'(m_dir));
    chk("door_engine_excl", 32'(bus.door && bus.engine != 2'b00), 32'd0);
    if (bus.engine == 2'b01) n_up_cyc++;
    if (bus.door) n_door_cyc++;
    if (bus.door && !prev_door) door_floors.push_back(bus.level_display);
    prev_door = bus.door;
  endtask

  task automatic cycle(input logic [F-1:0] c, input logic [F-1:0] u,
                       input logic [F-1:0] dn, input bit op, input bit cl);
    @(negedge clk);
    compare_outputs();
    bus.btn_num_in = c; bus.btn_up_out = u; bus.btn_down_out = dn;
    bus.open_btn = op; bus.close_btn = cl;
    model_step(c, u, dn, op, cl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_inputs();
    bus.btn_num_in = '0; bus.btn_up_out = '0; bus.btn_down_out = '0;
    bus.open_btn = 1'b0; bus.close_btn = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step('0, '0, '0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must drop to reset values before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_engine"}, 32'(bus.engine), 32'd0);
    chk({tag, "_rst_door"}, 32'(bus.door), 32'd0);
    chk({tag, "_rst_level"}, 32'(bus.level_display), 32'd1);
    chk({tag, "_rst_pending"}, 32'(bus.pending), 32'd0);
    chk({tag, "_rst_dir"}, 32'(bus.dir_up), 32'd1);
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    release_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    chk("init_engine", 32'(bus.engine), 32'd0);
    chk("init_door", 32'(bus.door), 32'd0);
    chk("init_level", 32'(bus.level_display), 32'd1);
    chk("init_pending", 32'(bus.pending), 32'd0);
    chk("init_dir", 32'(bus.dir_up), 32'd1);
    release_reset();

    idle(20);
    chk("s1_engine", 32'(bus.engine), 32'd0);
    chk("s1_door", 32'(bus.door), 32'd0);
    chk("s1_level", 32'(bus.level_display), 32'b000001);
    chk("s1_pending", 32'(bus.pending), 32'd0);

    // single cab call to floor 2
    n_up_cyc = 0; n_door_cyc = 0;
    cycle(6'b000100, '0, '0, 1'b0, 1'b0);
    idle(30);
    chk("s2_up_cycles", 32'(n_up_cyc), 32'd8);
    chk("s2_door_cycles", 32'(n_door_cyc), 32'd8);
    chk("s2_level", 32'(bus.level_display), 32'b000100);
    chk("s2_pending", 32'(bus.pending), 32'd0);

    // open hold extends dwell, close pulse cuts it short
    cycle('0, '0, '0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);
    n_door_cyc = 0;
    idle(15);
    chk("s3_dwell_after_release", 32'(n_door_cyc), 32'd8);
    cycle('0, '0, '0, 1'b1, 1'b0);
    idle(2);
    cycle('0, '0, '0, 1'b0, 1'b1);
    idle(1);
    chk("s3_close_edge1_door", 32'(bus.door), 32'd1);
    idle(1);
    chk("s3_close_edge2_door", 32'(bus.door), 32'd0);

    // back to floor 0, then cab 2 and hall-down 4 together
    idle(3);
    cycle(6'b000001, '0, '0, 1'b0, 1'b0);
    idle(40);
    chk("s4_at_floor0", 32'(bus.level_display), 32'b000001);
    door_floors.delete();
    cycle(6'b000100, '0, 6'b010000, 1'b0, 1'b0);
    idle(70);
    chk("s4_stop_count", 32'(door_floors.size()), 32'd2);
    chk("s4_first_stop", 32'(door_floors[0]), 32'b000100);
    chk("s4_second_stop", 32'(door_floors[1]), 32'b010000);
    chk("s4_dir_after", 32'(bus.dir_up), 32'd0);
    chk("s4_pending_after", 32'(bus.pending), 32'd0);

    // hall up at 3 while travelling up from 1 gives an intermediate stop
    cycle(6'b000010, '0, '0, 1'b0, 1'b0);
    idle(50);
    door_floors.delete();
    cycle(6'b100000, '0, '0, 1'b0, 1'b0);
    idle(3);
    cycle('0, 6'b001000, '0, 1'b0, 1'b0);
    idle(60);
    chk("s5a_stop_count", 32'(door_floors.size()), 32'd2);
    chk("s5a_first_stop", 32'(door_floors[0]), 32'b001000);
    chk("s5a_second_stop", 32'(door_floors[1]), 32'b100000);

    // hall down at 3 instead is passed going up and served on the way back
    cycle(6'b000010, '0, '0, 1'b0, 1'b0);
    idle(60);
    door_floors.delete();
    cycle(6'b100000, '0, '0, 1'b0, 1'b0);
    idle(3);
    cycle('0, '0, 6'b001000, 1'b0, 1'b0);
    idle(80);
    chk("s5b_stop_count", 32'(door_floors.size()), 32'd2);
    chk("s5b_first_stop", 32'(door_floors[0]), 32'b100000);
    chk("s5b_second_stop", 32'(door_floors[1]), 32'b001000);

    // reset while travelling between floors 2 and 3
    async_reset("s6a");
    cycle(6'b100000, '0, '0, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle(1);
      if (bus.level_display == 6'b000100) found = 1'b1;
    end
    chk("s6_reach_floor2", 32'(found), 32'd1);
    idle(1);
    chk("s6_moving_up", 32'(bus.engine), 32'd1);
    async_reset("s6");
    idle(5);
    chk("s6_pending_after", 32'(bus.pending), 32'd0);
    chk("s6_level_after", 32'(bus.level_display), 32'b000001);

    // random traffic
    for (int k = 0; k < 2500; k++) begin
      logic [F-1:0] c, u, dn;
      bit op, cl;
      c = '0; u = '0; dn = '0;
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, F - 1);
        case ($urandom_range(0, 2))
          0:       c[b] = 1'b1;
          1:       u[b] = 1'b1;
          default: dn[b] = 1'b1;
        endcase
      end
      op = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 24) == 0);
      cycle(c, u, dn, op, cl);
      if (k == 1200) async_reset("rnd");
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
